// File: rtl/sdram_arbit_if.sv
// Request/grant and SDRAM command-pin bundle between the sub-controllers and sdram_arbit.
// The tristate DQ bus stays a plain port on the arbiter, so it is not part of this bundle.
interface sdram_arbit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2
);
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;
  logic              init_end;

  logic              aref_req;
  logic [3:0]        aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_end;

  logic              wr_req;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              wr_end;

  logic              rd_req;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_end;

  logic              aref_en;
  logic              wr_en;
  logic              rd_en;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;

  // Arbiter side
  modport slave (
    input  init_cmd, init_ba, init_addr, init_end,
    input  aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
    input  wr_req, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data, wr_end,
    input  rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr
  );

  // Requester / pin side
  modport master (
    output init_cmd, init_ba, init_addr, init_end,
    output aref_req, aref_cmd, aref_ba, aref_addr, aref_end,
    output wr_req, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data, wr_end,
    output rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: hands the chip pins to init, then to refresh/write/read by fixed priority,
// with one NOP arbitration cycle between consecutive owners.
module sdram_arbit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  sdram_arbit_if.slave      bus,
  inout  logic [DATA_W-1:0] sdram_dq
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t state_q, state_d;
  logic   aref_en_q, aref_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;

  logic [3:0]        cmd_mux;
  logic [BA_W-1:0]   ba_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic              dq_oe;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (bus.init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (bus.aref_req)      state_d = ST_AREF;
        else if (bus.wr_req)   state_d = ST_WRITE;
        else if (bus.rd_req)   state_d = ST_READ;
      end
      ST_AREF:  if (bus.aref_end) state_d = ST_ARBIT;
      ST_WRITE: if (bus.wr_end)   state_d = ST_ARBIT;
      ST_READ:  if (bus.rd_end)   state_d = ST_ARBIT;
      default:  state_d = ST_INIT;
    endcase
    // Grants track the next state so they rise and fall on the same edge as ownership
    aref_en_d = (state_d == ST_AREF);
    wr_en_d   = (state_d == ST_WRITE);
    rd_en_d   = (state_d == ST_READ);
  end

  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = '1;
    addr_mux = '1;
    case (state_q)
      ST_INIT: begin
        cmd_mux  = bus.init_cmd;
        ba_mux   = bus.init_ba;
        addr_mux = bus.init_addr;
      end
      ST_AREF: begin
        cmd_mux  = bus.aref_cmd;
        ba_mux   = bus.aref_ba;
        addr_mux = bus.aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = bus.wr_cmd;
        ba_mux   = bus.wr_ba;
        addr_mux = bus.wr_addr;
      end
      ST_READ: begin
        cmd_mux  = bus.rd_cmd;
        ba_mux   = bus.rd_ba;
        addr_mux = bus.rd_addr;
      end
      default: ;
    endcase
  end

  assign dq_oe = (state_q == ST_WRITE) && bus.wr_sdram_en;

  assign sdram_dq = dq_oe ? bus.wr_sdram_data : 'z;

  assign bus.aref_en     = aref_en_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.sdram_cke   = 1'b1;
  assign bus.sdram_cs_n  = cmd_mux[3];
  assign bus.sdram_ras_n = cmd_mux[2];
  assign bus.sdram_cas_n = cmd_mux[1];
  assign bus.sdram_we_n  = cmd_mux[0];
  assign bus.sdram_ba    = ba_mux;
  assign bus.sdram_addr  = addr_mux;

endmodule
